// File: rtl/carry_select_adder.sv
// Registered carry-select adder: ripple block 0, dual-ripple select blocks above.
// Define CARRY_SELECT_ADDER_OVF_EN to add a registered signed-overflow output.
module carry_select_adder #(
    parameter int WIDTH   = 4,
    parameter int BLOCK_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CARRY_SELECT_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NBLK = (WIDTH + BLOCK_W - 1) / BLOCK_W;

    logic [NBLK:0]    blk_c;
    logic [WIDTH-1:0] s_sel;

    assign blk_c[0] = cin;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_blk
            localparam int LO = gi * BLOCK_W;
            localparam int BW = (WIDTH - LO < BLOCK_W) ? (WIDTH - LO) : BLOCK_W;

            if (gi == 0) begin : g_rip
                logic [BW:0] c;
                assign c[0] = blk_c[0];
                for (gj = 0; gj < BW; gj++) begin : g_bit
                    assign s_sel[LO+gj] = a[LO+gj] ^ b[LO+gj] ^ c[gj];
                    assign c[gj+1] = (a[LO+gj] & b[LO+gj])
                                   | (c[gj] & (a[LO+gj] ^ b[LO+gj]));
                end
                assign blk_c[gi+1] = c[BW];
            end else begin : g_sel
                logic [BW:0]   c0, c1;
                logic [BW-1:0] s0, s1;
                assign c0[0] = 1'b0;
                assign c1[0] = 1'b1;
                for (gj = 0; gj < BW; gj++) begin : g_bit
                    assign s0[gj] = a[LO+gj] ^ b[LO+gj] ^ c0[gj];
                    assign s1[gj] = a[LO+gj] ^ b[LO+gj] ^ c1[gj];
                    assign c0[gj+1] = (a[LO+gj] & b[LO+gj])
                                    | (c0[gj] & (a[LO+gj] ^ b[LO+gj]));
                    assign c1[gj+1] = (a[LO+gj] & b[LO+gj])
                                    | (c1[gj] & (a[LO+gj] ^ b[LO+gj]));
                end
                // carry from the block below picks the precomputed result
                assign s_sel[LO+:BW] = blk_c[gi] ? s1 : s0;
                assign blk_c[gi+1]   = blk_c[gi] ? c1[BW] : c0[BW];
            end
        end
    endgenerate

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

    always_comb begin
        sum_d  = s_sel;
        cout_d = blk_c[NBLK];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef CARRY_SELECT_ADDER_OVF_EN
    logic ovf_d, ovf_q;

    // carry into the MSB is recovered as a^b^sum at that bit
    always_comb begin
        ovf_d = a[WIDTH-1] ^ b[WIDTH-1] ^ s_sel[WIDTH-1] ^ blk_c[NBLK];
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_carry_select_adder.sv
// Bench for carry_select_adder: directed cases, exhaustive 4-bit sweep
// over BLOCK_W 1..4, and random 8-bit operands on a BLOCK_W=3 instance.
module tb_carry_select_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       cin;

    logic [3:0] s4 [1:4];
    logic       c4 [1:4];
    logic       o4 [1:4];
    logic [7:0] s8;
    logic       c8;
    logic       o8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        carry_select_adder #(.WIDTH(4), .BLOCK_W(g)) u_dut (
            .clk  (clk),
            .rst  (rst),
            .a    (a4),
            .b    (b4),
            .cin  (cin),
`ifdef CARRY_SELECT_ADDER_OVF_EN
            .ovf  (o4[g]),
`endif
            .sum  (s4[g]),
            .cout (c4[g])
        );
    end

    carry_select_adder #(.WIDTH(8), .BLOCK_W(3)) u_dut8 (
        .clk  (clk),
        .rst  (rst),
        .a    (a8),
        .b    (b8),
        .cin  (cin),
`ifdef CARRY_SELECT_ADDER_OVF_EN
        .ovf  (o8),
`endif
        .sum  (s8),
        .cout (c8)
    );

`ifndef CARRY_SELECT_ADDER_OVF_EN
    initial begin
        for (int k = 1; k <= 4; k++) o4[k] = 1'b0;
        o8 = 1'b0;
    end
`endif

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // drive one operand set, let one edge pass, compare every instance
    task automatic step(input logic r, input logic [3:0] x, input logic [3:0] y,
                        input logic c, input logic [7:0] x8, input logic [7:0] y8);
        int e4, e8, s;
        logic v4, v8;
        rst = r; a4 = x; b4 = y; cin = c; a8 = x8; b8 = y8;
        @(posedge clk);
        #1;
        e4 = r ? 0 : int'(x) + int'(y) + int'(c);
        e8 = r ? 0 : int'(x8) + int'(y8) + int'(c);
        s  = int'($signed(x)) + int'($signed(y)) + int'(c);
        v4 = !r && (s > 7 || s < -8);
        s  = int'($signed(x8)) + int'($signed(y8)) + int'(c);
        v8 = !r && (s > 127 || s < -128);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("w4_bw%0d_%h_%h_%b_r%b", k, x, y, c, r),
                32'({c4[k], s4[k]}), 32'(e4));
`ifdef CARRY_SELECT_ADDER_OVF_EN
            chk($sformatf("ovf4_bw%0d_%h_%h_%b", k, x, y, c),
                32'(o4[k]), 32'(v4));
`endif
        end
        chk($sformatf("w8_bw3_%h_%h_%b_r%b", x8, y8, c, r),
            32'({c8, s8}), 32'(e8));
`ifdef CARRY_SELECT_ADDER_OVF_EN
        chk($sformatf("ovf8_%h_%h_%b", x8, y8, c), 32'(o8), 32'(v8));
`else
        if (v4 && v8 && o4[1] && o8) $display("unexpected ovf state");
`endif
    endtask

    initial begin
        // reset held with all-ones operands, then release
        step(1'b1, 4'hF, 4'hF, 1'b1, 8'hFF, 8'hFF);
        step(1'b1, 4'hF, 4'hF, 1'b1, 8'hFF, 8'hFF);
        step(1'b0, 4'hF, 4'hF, 1'b1, 8'hFF, 8'hFF);
        // directed cases and back-to-back throughput
        step(1'b0, 4'h7, 4'h8, 1'b0, 8'h7F, 8'h80);
        step(1'b0, 4'hF, 4'hF, 1'b1, 8'hFF, 8'hFF);
        step(1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 4'h3, 4'h1, 1'b0, 8'h03, 8'h01);
        step(1'b0, 4'h5, 4'hB, 1'b0, 8'h55, 8'hAB);
        step(1'b0, 4'h6, 4'h9, 1'b1, 8'h5A, 8'hA5);
        step(1'b0, 4'h7, 4'h1, 1'b0, 8'h7F, 8'h01);
        // reset pulse between two operand sets
        step(1'b0, 4'h2, 4'h3, 1'b0, 8'h12, 8'h34);
        step(1'b1, 4'h9, 4'h9, 1'b1, 8'h99, 8'h99);
        step(1'b0, 4'h4, 4'h5, 1'b1, 8'h44, 8'h55);
        // exhaustive 4-bit sweep with random 8-bit operands alongside
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int c = 0; c < 2; c++)
                    step(1'b0, 4'(i), 4'(j), 1'(c),
                         8'($urandom), 8'($urandom));
        // random stream including occasional reset
        for (int n = 0; n < 300; n++)
            step(($urandom_range(0, 19) == 0), 4'($urandom), 4'($urandom),
                 1'($urandom), 8'($urandom), 8'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/carry_select_adder.md
Name: carry_select_adder

Overview:
- Registered N-bit carry-select adder: computes sum = a + b + cin and registers the result and carry-out.
- Datapath is split into fixed-size blocks. Block 0 ripples from cin. Every higher block precomputes two results, one for carry-in 0 and one for carry-in 1, then selects between them with the carry from the block below.
- Used as a general-purpose low-latency adder leaf in arithmetic datapaths.

Parameters:
- WIDTH, 4, operand and sum width in bits (>=1).
- BLOCK_W, 2, bits per carry-select block (1..WIDTH). If WIDTH is not a multiple of BLOCK_W, the top block is narrower.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in
- sum  output  WIDTH  registered sum, (a+b+cin) mod 2^WIDTH
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin

Behaviour:
- One clock; all state updates on the rising edge of clk.
- Reset: if rst=1 at a rising edge, sum<=0 and cout<=0. rst has priority over new operands. Reset asserted mid-stream discards the in-flight result. The first valid result appears one cycle after rst deasserts.
- Latency: 1 cycle. The result for a/b/cin sampled at edge k is visible on sum/cout after edge k and held until edge k+1.
- No handshake. A new operand set is accepted every cycle (throughput 1/cycle).
- Arithmetic: {cout,sum} = a + b + cin, computed at WIDTH+1 bits with no truncation before the register.
- Block structure, mandatory:
  - Block 0 is a ripple-carry adder seeded by cin.
  - Each block i>0 contains two ripple adders, seeded with 0 and 1.
  - A 2:1 mux per block selects sum bits and block carry-out using the carry-out of block i-1.
  - cout is the selected carry of the top block.
- Boundaries:
  - all-ones + all-ones + 1 gives sum all-ones and cout 1.
  - all-zeros + all-zeros + 0 gives 0, 0.
  - a + ~a + 1 wraps to sum 0 with cout 1.
- BLOCK_W=WIDTH degenerates to a plain ripple adder. Results must be identical for every legal BLOCK_W.
- Outputs are never X after reset, including when inputs are held constant.

Optional Feature:
- Macro CARRY_SELECT_ADDER_OVF_EN.
- When defined, an extra output port ovf (1 bit, registered, same latency as sum) is present. ovf = signed two's-complement overflow of a+b+cin: carry into the MSB XOR carry out of the MSB. ovf resets to 0.
- When undefined, the ovf port and its logic do not exist, and the rest of the behaviour is unchanged.

Test Plan:
- Reset held 2 cycles with a=1111, b=1111, cin=1: sum=0000, cout=0 throughout. Release rst; the next edge gives sum=1111, cout=1.
- a=0111, b=1000, cin=0: after 1 edge, sum=1111, cout=0. With OVF_EN, ovf=0.
- a=1111, b=1111, cin=1: sum=1111, cout=1. Then a=0000, b=0000, cin=0 on the next cycle: sum=0000, cout=0. Checks back-to-back throughput.
- Carry across block boundary, with a=0011, b=0001, cin=0: sum=0100, cout=0. Then a=0101, b=1011, cin=0: sum=0000, cout=1.
- Assert rst for one cycle between two operand sets: the outputs show 0/0 for that cycle, and the following operand result appears with normal 1-cycle latency.
- Exhaustive sweep of all a, b, cin for WIDTH=4 and BLOCK_W in {1,2,3,4}: every registered {cout,sum} equals the reference a+b+cin. With OVF_EN, a=0111, b=0001, cin=0 gives ovf=1.
